gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Next-generation direction predictor: global-history (gshare) indexed table of saturating counters, parametrised in table depth, counter width and history length.
- Keeps a speculative global history register (GHR). It is shifted on every prediction and repaired on a mispredicted update.
- Sits in fetch alongside the PC; the update port is driven from execute/retire, which returns the history snapshot issued with each prediction.
- Provides performance counters for updates and mispredicts.

Parameters:
- LOG_ENTRIES, 12, log2 of counter-table entries; PC index bits are pc[LOG_ENTRIES+1:2].
- CTR_BITS, 2, width of each saturating counter (legal range 1..4).
- HIST_BITS, 8, GHR length (legal range 1..LOG_ENTRIES); elaboration error outside range.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pred_valid  in  1  a prediction is consumed this cycle (advances GHR)
- pc  in  32  fetch PC (4-byte aligned)
- taken  out  1  predicted direction (counter MSB)
- pred_history  out  HIST_BITS  GHR value used for this prediction; the pipeline carries it to update
- update  in  1  resolve a branch this cycle
- update_pc  in  32  PC of the resolved branch
- update_history  in  HIST_BITS  pred_history captured at that branch's prediction
- update_pred_taken  in  1  direction originally predicted
- was_taken  in  1  actual direction
- update_count  out  32  number of updates since reset
- mispredict_count  out  32  number of updates with update_pred_taken != was_taken

Behaviour:
- Index function: idx(p,h) = p[LOG_ENTRIES+1:2] XOR zero-extend(h) to LOG_ENTRIES bits.
- Prediction is combinational, zero latency:
  - taken = table[idx(pc, ghr)][CTR_BITS-1].
  - pred_history = ghr.
  - Both are valid whether or not pred_valid is high.
- GHR, new bit entering at LSB:
  - pred_valid=1 and no recovery: ghr <= {ghr[HIST_BITS-2:0], taken}.
  - For HIST_BITS=1: ghr <= taken.
- Recovery: update=1 and mispredict (update_pred_taken != was_taken): ghr <= {update_history[HIST_BITS-2:0], was_taken}.
  - Recovery has priority over a same-cycle pred_valid; that prediction's shift is discarded.
- Counter update, when update=1, on counter c = table[idx(update_pc, update_history)]:
  - was_taken=1: c <= c+1, saturating at 2^CTR_BITS-1.
  - was_taken=0: c <= c-1, saturating at 0.
  - At saturation the counter holds its value (no write needed).
- Same-cycle predict and update to the same entry: the prediction reads the pre-update value; no bypass. The write is visible from the next cycle.
- Perf counters, when update=1:
  - update_count += 1.
  - mispredict_count += 1 if mispredict.
  - Both wrap modulo 2^32.
- Reset (reset=0, asynchronous, may occur mid-stream):
  - All table entries = 2^(CTR_BITS-1) (weakly taken).
  - ghr = 0.
  - update_count = 0, mispredict_count = 0.
  - Therefore taken=1 and pred_history=0 immediately after reset.
- update_pred_taken is trusted, not rechecked against the table.
- X on update_* when update=0 must not affect state.

Decomposition:
- Package bp_pkg holds:
  - sat_ctr_t, parametrised via typedef in the module using CTR_BITS.
  - Functions sat_inc/sat_dec(value, max).
  - Function gshare_index.
  - Constant WEAK_TAKEN computation.
- Sub-module ghr_unit (HIST_BITS): owns the GHR, the shift on pred_valid, and recovery priority. Outputs ghr.
- The table and perf counters stay in gshare_predictor.

Test Plan:
- Reset defaults: after reset with pc=0x100, expect taken=1, pred_history=0, update_count=0, mispredict_count=0; verify via async assertion mid-run.
- Saturation, CTR_BITS=2, HIST_BITS=8:
  - Four updates at update_pc=0x40, update_history=0, was_taken=1, update_pred_taken=1 -> counter at idx 0x10 reaches 3 and stays 3; mispredict_count=0.
  - Then three not-taken updates -> counter=0, taken=0 for pc=0x40 with ghr=0.
- GHR shift: pred_valid for 3 cycles with taken=1,1,0 from reset -> pred_history = 0x00, 0x01, 0x03, then 0x06 on the fourth cycle.
- Recovery priority: ghr=0x06; same cycle pred_valid=1 and mispredicted update with update_history=0x05, was_taken=0 -> next ghr=0x0A; mispredict_count increments by 1.
- Index XOR: update at update_pc=0x44, update_history=0x03, was_taken=0 x2 -> entry 0x11^0x03=0x12 decremented to 0. pc=0x48 with ghr=0 (idx 0x12) predicts taken=0; entry 0x11 is still weakly taken.
- Parametrisation: CTR_BITS=3, HIST_BITS=LOG_ENTRIES=4 -> reset counters=4; saturates at 7 and 0; GHR wraps using the full 4 bits. Perf counter wrap from forced 0xFFFFFFFF to 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: saturating counter arithmetic, the gshare
// index hash and the reset value of a counter.
package bp_pkg;

  // Widest counter any predictor instance may use; helpers operate at this width.
  localparam int unsigned MaxCtrBits = 4;

  typedef logic [MaxCtrBits-1:0] ctr_val_t;

  // Increment, holding at max.
  function automatic ctr_val_t sat_inc(input ctr_val_t value, input ctr_val_t max);
    return (value >= max) ? max : value + 1'b1;
  endfunction

  // Decrement, holding at zero; an out-of-range value is clamped to max.
  function automatic ctr_val_t sat_dec(input ctr_val_t value, input ctr_val_t max);
    if (value > max) begin
      return max;
    end
    return (value == '0) ? '0 : value - 1'b1;
  endfunction

  // Word-aligned PC bits XOR zero-extended history, truncated to log_entries bits.
  function automatic logic [31:0] gshare_index(input logic [31:0] pc, input logic [31:0] hist,
                                               input int unsigned log_entries);
    logic [31:0] mask;
    mask = (32'd1 << log_entries) - 32'd1;
    return ((pc >> 2) ^ hist) & mask;
  endfunction

  // Weakly-taken encoding: only the MSB set.
  function automatic int unsigned weak_taken(input int unsigned ctr_bits);
    return 32'd1 << (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction port and execute-side update port of the gshare predictor.
//   master: drives pred_valid/pc and the update_* / was_taken resolve signals.
//   slave : returns taken/pred_history and the perf counters.
interface gshare_predictor_if #(
  parameter int unsigned HIST_BITS = 8
);
  logic                 pred_valid;
  logic [31:0]          pc;
  logic                 taken;
  logic [HIST_BITS-1:0] pred_history;
  logic                 update;
  logic [31:0]          update_pc;
  logic [HIST_BITS-1:0] update_history;
  logic                 update_pred_taken;
  logic                 was_taken;
  logic [31:0]          update_count;
  logic [31:0]          mispredict_count;

  modport master (
    output pred_valid, pc, update, update_pc, update_history, update_pred_taken, was_taken,
    input  taken, pred_history, update_count, mispredict_count
  );

  modport slave (
    input  pred_valid, pc, update, update_pc, update_history, update_pred_taken, was_taken,
    output taken, pred_history, update_count, mispredict_count
  );
endinterface

// File: rtl/ghr_unit.sv
// Speculative global history register.
//   clk, reset        : clock, asynchronous active-low reset
//   pred_valid        : shift pred_taken in at the LSB
//   recover           : mispredict repair; wins over a same-cycle shift
//   recover_history   : history snapshot of the mispredicted branch
//   recover_taken     : resolved direction of that branch
//   ghr               : current history
module ghr_unit #(
  parameter int unsigned HIST_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic                 pred_taken,
  input  logic                 recover,
  input  logic [HIST_BITS-1:0] recover_history,
  input  logic                 recover_taken,
  output logic [HIST_BITS-1:0] ghr
);

  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  // Shift-and-insert written as a shift so HIST_BITS=1 needs no special case.
  always_comb begin
    ghr_d = ghr_q;
    if (recover) begin
      ghr_d = (recover_history << 1) | HIST_BITS'(recover_taken);
    end else if (pred_valid) begin
      ghr_d = (ghr_q << 1) | HIST_BITS'(pred_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr = ghr_q;

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: table of saturating counters indexed by PC XOR global history.
//   clk, reset : clock, asynchronous active-low reset
//   bp         : slave side of gshare_predictor_if
//                prediction (combinational): pc, pred_valid -> taken, pred_history
//                resolve: update, update_pc, update_history, update_pred_taken, was_taken
//                perf: update_count, mispredict_count (wrap at 2^32)
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned LOG_ENTRIES = 12,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned HIST_BITS   = 8
) (
  input logic               clk,
  input logic               reset,
  gshare_predictor_if.slave bp
);

  if (CTR_BITS < 1 || CTR_BITS > MaxCtrBits) begin : g_ctr_bits_check
    $error("gshare_predictor: CTR_BITS must be in 1..4");
  end
  if (HIST_BITS < 1 || HIST_BITS > LOG_ENTRIES) begin : g_hist_bits_check
    $error("gshare_predictor: HIST_BITS must be in 1..LOG_ENTRIES");
  end
  if (LOG_ENTRIES < 1 || LOG_ENTRIES > 30) begin : g_log_entries_check
    $error("gshare_predictor: LOG_ENTRIES must be in 1..30");
  end

  typedef logic [CTR_BITS-1:0] sat_ctr_t;

  localparam int unsigned Entries   = 1 << LOG_ENTRIES;
  localparam sat_ctr_t    WeakTaken = sat_ctr_t'(weak_taken(CTR_BITS));
  localparam sat_ctr_t    CtrMax    = '1;

  sat_ctr_t               ctr_table_q [Entries];
  logic [HIST_BITS-1:0]   ghr;
  logic [LOG_ENTRIES-1:0] pred_idx, upd_idx;
  sat_ctr_t               upd_ctr, upd_ctr_d;
  logic                   mispredict;
  logic [31:0]            update_count_q, mispredict_count_q;

  assign pred_idx = LOG_ENTRIES'(gshare_index(bp.pc, 32'(ghr), LOG_ENTRIES));
  assign upd_idx  = LOG_ENTRIES'(gshare_index(bp.update_pc, 32'(bp.update_history),
                                              LOG_ENTRIES));

  // Prediction reads the registered table: a same-cycle update is not bypassed.
  assign bp.taken        = ctr_table_q[pred_idx][CTR_BITS-1];
  assign bp.pred_history = ghr;

  // Trust the pipeline's recorded prediction rather than re-reading the table.
  assign mispredict = bp.update_pred_taken ^ bp.was_taken;

  ghr_unit #(
    .HIST_BITS(HIST_BITS)
  ) u_ghr (
    .clk            (clk),
    .reset          (reset),
    .pred_valid     (bp.pred_valid),
    .pred_taken     (bp.taken),
    .recover        (bp.update & mispredict),
    .recover_history(bp.update_history),
    .recover_taken  (bp.was_taken),
    .ghr            (ghr)
  );

  assign upd_ctr = ctr_table_q[upd_idx];

  always_comb begin
    upd_ctr_d = upd_ctr;
    if (bp.was_taken) begin
      upd_ctr_d = sat_ctr_t'(sat_inc(ctr_val_t'(upd_ctr), ctr_val_t'(CtrMax)));
    end else begin
      upd_ctr_d = sat_ctr_t'(sat_dec(ctr_val_t'(upd_ctr), ctr_val_t'(CtrMax)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        ctr_table_q[i] <= WeakTaken;
      end
    end else if (bp.update) begin
      ctr_table_q[upd_idx] <= upd_ctr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bp.update) begin
      update_count_q <= update_count_q + 32'd1;
      if (mispredict) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign bp.update_count     = update_count_q;
  assign bp.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_gshare_predictor.sv
`timescale 1ns/1ps
module tb_gshare_predictor;

  localparam int unsigned AL = 12, AC = 2, AH = 8;
  localparam int unsigned BL = 4,  BC = 3, BH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;

  gshare_predictor_if #(.HIST_BITS(AH)) ifa ();
  gshare_predictor_if #(.HIST_BITS(BH)) ifb ();

  gshare_predictor #(.LOG_ENTRIES(AL), .CTR_BITS(AC), .HIST_BITS(AH)) dut_a (
    .clk  (clk),
    .reset(reset_a),
    .bp   (ifa)
  );

  gshare_predictor #(.LOG_ENTRIES(BL), .CTR_BITS(BC), .HIST_BITS(BH)) dut_s (
    .clk  (clk),
    .reset(reset_b),
    .bp   (ifb)
  );

  typedef struct {
    logic        taken;
    int unsigned hist;
    logic [31:0] ucnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain integer counters per entry, history as an integer.
  int unsigned cfg_l[2] = '{AL, BL};
  int unsigned cfg_c[2] = '{AC, BC};
  int unsigned cfg_h[2] = '{AH, BH};
  int unsigned m_tab[2][4096];
  int unsigned m_ghr[2];
  logic [31:0] m_uc[2];
  logic [31:0] m_mc[2];

  function automatic int unsigned midx(input int k, input int unsigned p, input int unsigned h);
    return ((p / 4) ^ h) % (32'd1 << cfg_l[k]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      chk("a.taken", 32'(ifa.taken), 32'(ea.taken));
      chk("a.pred_history", 32'(ifa.pred_history), ea.hist);
      chk("a.update_count", ifa.update_count, ea.ucnt);
      chk("a.mispredict_count", ifa.mispredict_count, ea.mcnt);
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      chk("b.taken", 32'(ifb.taken), 32'(eb.taken));
      chk("b.pred_history", 32'(ifb.pred_history), eb.hist);
      chk("b.update_count", ifb.update_count, eb.ucnt);
      chk("b.mispredict_count", ifb.mispredict_count, eb.mcnt);
    end
  end

  task automatic model_reset(input int k);
    for (int i = 0; i < (1 << cfg_l[k]); i++) m_tab[k][i] = 32'd1 << (cfg_c[k] - 1);
    m_ghr[k] = 0;
    m_uc[k]  = '0;
    m_mc[k]  = '0;
  endtask

  task automatic push_exp(input int k, input exp_t e);
    if (k == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic drive(input int k, input bit pv, input int unsigned pc, input bit upd,
                       input int unsigned upc, input int unsigned uh, input bit upt,
                       input bit wt);
    if (k == 0) begin
      ifa.pred_valid = pv; ifa.pc = pc; ifa.update = upd; ifa.update_pc = upc;
      ifa.update_history = AH'(uh); ifa.update_pred_taken = upt; ifa.was_taken = wt;
    end else begin
      ifb.pred_valid = pv; ifb.pc = pc; ifb.update = upd; ifb.update_pc = upc;
      ifb.update_history = BH'(uh); ifb.update_pred_taken = upt; ifb.was_taken = wt;
    end
  endtask

  // One clock of stimulus, called 1ns after a rising edge.
  task automatic cyc(input int k, input bit pv, input int unsigned pc, input bit upd,
                     input int unsigned upc, input int unsigned uh, input bit upt,
                     input bit wt);
    exp_t e;
    int unsigned i, hmask, cmax;
    hmask = (32'd1 << cfg_h[k]) - 1;
    cmax  = (32'd1 << cfg_c[k]) - 1;
    uh    = uh & hmask;
    drive(k, pv, pc, upd, upc, uh, upt, wt);
    e.taken = (m_tab[k][midx(k, pc, m_ghr[k])] >= (32'd1 << (cfg_c[k] - 1)));
    e.hist  = m_ghr[k];
    e.ucnt  = m_uc[k];
    e.mcnt  = m_mc[k];
    push_exp(k, e);
    if (upd) begin
      i = midx(k, upc, uh);
      if (wt && m_tab[k][i] < cmax) m_tab[k][i]++;
      else if (!wt && m_tab[k][i] > 0) m_tab[k][i]--;
      m_uc[k]++;
      if (upt != wt) m_mc[k]++;
    end
    if (upd && upt != wt) m_ghr[k] = (uh * 2 + 32'(wt)) & hmask;
    else if (pv) m_ghr[k] = (m_ghr[k] * 2 + 32'(e.taken)) & hmask;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle so the next falling edge sees it before any clock edge.
  task automatic do_reset(input int k);
    exp_t e;
    if (k == 0) reset_a = 1'b0;
    else reset_b = 1'b0;
    drive(k, 1'b0, 32'h100, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    model_reset(k);
    e.taken = 1'b1;
    e.hist  = 0;
    e.ucnt  = '0;
    e.mcnt  = '0;
    push_exp(k, e);
    @(posedge clk);
    #1;
    if (k == 0) reset_a = 1'b1;
    else reset_b = 1'b1;
  endtask

  task automatic rand_cyc(input int k);
    cyc(k, 1'($urandom_range(0, 1)), $urandom_range(0, 63) * 4, 1'($urandom_range(0, 1)),
        $urandom_range(0, 63) * 4, $urandom, 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // ---------------- instance A: 4096 x 2-bit, 8-bit history ----------------
    do_reset(0);
    cyc(0, 0, 'h100, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 'h40, 1, 'h40, 0, 1, 1);
    cyc(0, 0, 'h40, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 'h40, 1, 'h40, 0, 0, 0);
    cyc(0, 0, 'h40, 0, 0, 0, 0, 0);

    // GHR shift: train entry 0x13 not-taken so the third prediction is 0.
    do_reset(0);
    repeat (2) cyc(0, 0, 'h100, 1, 'h4C, 0, 0, 0);
    cyc(0, 1, 'h100, 0, 0, 0, 0, 0);
    cyc(0, 1, 'h100, 0, 0, 0, 0, 0);
    cyc(0, 1, 'h40, 0, 0, 0, 0, 0);
    cyc(0, 0, 'h100, 0, 0, 0, 0, 0);

    // Recovery beats a same-cycle shift.
    cyc(0, 1, 'h100, 1, 'h300, 'h05, 1, 0);
    cyc(0, 0, 'h100, 0, 0, 0, 0, 0);

    // Index XOR, then repair ghr back to 0 with a mispredict.
    repeat (2) cyc(0, 0, 'h100, 1, 'h44, 'h03, 0, 0);
    cyc(0, 0, 'h100, 1, 'h200, 0, 1, 0);
    cyc(0, 0, 'h48, 0, 0, 0, 0, 0);
    cyc(0, 0, 'h44, 0, 0, 0, 0, 0);

    // No bypass: predict and update the same entry together.
    repeat (2) cyc(0, 0, 'h48, 1, 'h48, 0, 1, 1);
    cyc(0, 0, 'h48, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset(0);
      else rand_cyc(0);
    end
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);

    // ---------------- instance B: 16 x 3-bit, 4-bit history ----------------
    do_reset(1);
    repeat (5) cyc(1, 0, 'h8, 1, 'h8, 0, 1, 1);
    cyc(1, 0, 'h8, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 'h8, 1, 'h8, 0, 0, 0);
    cyc(1, 0, 'h8, 0, 0, 0, 0, 0);
    repeat (6) cyc(1, 0, 'h8, 1, 'h8, 0, 0, 0);
    cyc(1, 0, 'h8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, $urandom_range(0, 15) * 4, 0, 0, 0, 0, 0);

    // Perf counter wrap from a forced all-ones value.
    force dut_s.update_count_q = 32'hFFFF_FFFF;
    force dut_s.mispredict_count_q = 32'hFFFF_FFFF;
    #1;
    release dut_s.update_count_q;
    release dut_s.mispredict_count_q;
    m_uc[1] = 32'hFFFF_FFFF;
    m_mc[1] = 32'hFFFF_FFFF;
    cyc(1, 0, 'h0, 1, 'h4, 'h2, 1, 0);
    cyc(1, 0, 'h0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      if (i == 100) do_reset(1);
      else rand_cyc(1);
    end

    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_a.size() + q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
